// File: rtl/alu_seq.sv
// Registered, handshaked ALU with signed SET predicates
// and a one-bit-per-cycle unsigned shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    input  logic [2:0]       cmp_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcd;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mpl;

    logic accept, take, load, mul_done;
    logic op_and, op_or, op_add, op_sub;
    logic op_nor, op_nand, op_set, op_mul;

    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic             lt, eq, pred;

    logic [WIDTH-1:0] res_d;
    logic             cout_d, ovf_d;

    assign op_and  = alu_ctrl == 4'b0000;
    assign op_or   = alu_ctrl == 4'b0001;
    assign op_add  = alu_ctrl == 4'b0010;
    assign op_sub  = alu_ctrl == 4'b0110;
    assign op_nor  = alu_ctrl == 4'b1100;
    assign op_nand = alu_ctrl == 4'b1101;
    assign op_set  = alu_ctrl == 4'b0111;
    assign op_mul  = alu_ctrl == 4'b1000;

    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign mul_done = (state == S_MUL) && (cnt == LAST);
    assign load     = (accept && !op_mul) || mul_done;
    assign acc_nxt  = acc + (mpl[0] ? mcd : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept && op_mul) state_nxt = S_MUL;
            S_MUL:  if (cnt == LAST)      state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            mcd <= '0;
            mpl <= '0;
        end else if (accept && op_mul) begin
            cnt <= '0;
            acc <= '0;
            mcd <= {{WIDTH{1'b0}}, src1};
            mpl <= src2;
        end else if (state == S_MUL) begin
            cnt <= mul_done ? '0 : cnt + 1'b1;
            acc <= acc_nxt;
            mcd <= mcd << 1;
            mpl <= mpl >> 1;
        end
    end

    // SUB reuses the adder: src1 + ~src2 + 1
    assign opb = op_sub ? ~src2 : src2;
    assign sum = {1'b0, src1} + {1'b0, opb}
               + (WIDTH+1)'(op_sub);

    assign lt = $signed(src1) < $signed(src2);
    assign eq = src1 == src2;

    always_comb begin
        pred = 1'b0;
        unique case (cmp_ctrl)
            3'b000:  pred = lt;
            3'b001:  pred = !lt && !eq;
            3'b010:  pred = lt || eq;
            3'b011:  pred = !lt;
            3'b100:  pred = eq;
            3'b101:  pred = !eq;
            default: pred = 1'b0;
        endcase
    end

    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        if (mul_done) begin
            res_d = acc_nxt[WIDTH-1:0];
            ovf_d = |acc_nxt[2*WIDTH-1:WIDTH];
        end else begin
            unique case (1'b1)
                op_and:  res_d = src1 & src2;
                op_or:   res_d = src1 | src2;
                op_nor:  res_d = ~(src1 | src2);
                op_nand: res_d = ~(src1 & src2);
                op_set:  res_d = {{(WIDTH-1){1'b0}}, pred};
                op_add, op_sub: begin
                    res_d  = sum[WIDTH-1:0];
                    cout_d = sum[WIDTH];
                    ovf_d  = (src1[WIDTH-1] == opb[WIDTH-1])
                          && (sum[WIDTH-1] != src1[WIDTH-1]);
                end
                default: res_d = '0;
            endcase
        end
    end

    // a load on the same edge as a take keeps out_valid high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= res_d;
            zero      <= ~|res_d;
            cout      <= cout_d;
            overflow  <= ovf_d;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against
// an arithmetic reference model and a result queue.
module tb_alu_seq;

    localparam logic [3:0] AND_ = 4'b0000;
    localparam logic [3:0] OR_  = 4'b0001;
    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0110;
    localparam logic [3:0] NOR_ = 4'b1100;
    localparam logic [3:0] NAND_ = 4'b1101;
    localparam logic [3:0] SET  = 4'b0111;
    localparam logic [3:0] MULU = 4'b1000;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [31:0] src1, src2, result;
    logic [3:0]  alu_ctrl;
    logic [2:0]  cmp_ctrl;
    logic        zero, cout, overflow;

    logic       v8, rdy8, ov8_valid, ordy8;
    logic [7:0] a8, b8, res8;
    logic [3:0] ctl8;
    logic [2:0] cmp8;
    logic       z8, c8, ov8;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2),
        .alu_ctrl(alu_ctrl), .cmp_ctrl(cmp_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero),
        .cout(cout), .overflow(overflow)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8),
        .src1(a8), .src2(b8),
        .alu_ctrl(ctl8), .cmp_ctrl(cmp8),
        .out_valid(ov8_valid), .out_ready(ordy8),
        .result(res8), .zero(z8),
        .cout(c8), .overflow(ov8)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_take = 0;
    logic [34:0] exp_q[$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    // returns {overflow, cout, zero, result}
    function automatic logic [34:0] model(
        input logic [3:0] op, input logic [2:0] cmp,
        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        logic [32:0] s;
        longint sp;
        logic [63:0] p;
        r = 0; c = 0; v = 0;
        case (op)
            AND_:  r = a & b;
            OR_:   r = a | b;
            NOR_:  r = ~(a | b);
            NAND_: r = ~(a & b);
            ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                sp = longint'($signed(a)) + longint'($signed(b));
                v = sp > SMAX || sp < SMIN;
            end
            SUB: begin
                r = a - b;
                c = a >= b;
                sp = longint'($signed(a)) - longint'($signed(b));
                v = sp > SMAX || sp < SMIN;
            end
            SET: begin
                case (cmp)
                    3'd0: r = 32'($signed(a) < $signed(b));
                    3'd1: r = 32'($signed(a) > $signed(b));
                    3'd2: r = 32'($signed(a) <= $signed(b));
                    3'd3: r = 32'($signed(a) >= $signed(b));
                    3'd4: r = 32'(a == b);
                    3'd5: r = 32'(a != b);
                    default: r = 0;
                endcase
            end
            MULU: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                v = |p[63:32];
            end
            default: r = 0;
        endcase
        return {v, c, r == 0, r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("spurious_out", 1, 0);
            else
                chk("result", {overflow, cout, zero, result},
                    exp_q.pop_front());
            n_take++;
        end
    end

    task automatic send(input logic [3:0] op,
                        input logic [2:0] cmp,
                        input logic [31:0] a,
                        input logic [31:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        alu_ctrl = op;
        cmp_ctrl = cmp;
        src1 = a;
        src2 = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(op, cmp, a, b));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops [10] = '{AND_, OR_, ADD, SUB, NOR_,
                             NAND_, SET, MULU, 4'b0011, 4'b1111};
    logic [31:0] r0;
    int t0, nv;
    bit done;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        src1 = 0; src2 = 0; alu_ctrl = 0; cmp_ctrl = 0;
        v8 = 0; a8 = 0; b8 = 0; ctl8 = 0; cmp8 = 0; ordy8 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {out_valid, result, zero, cout, overflow}, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        send(ADD, 0, 32'h7FFF_FFFF, 32'h0000_0001);
        in_valid = 1'b0;
        chk("add_lat", out_valid, 1);
        chk("add_ovf", {overflow, cout, zero, result},
            {3'b100, 32'h8000_0000});
        send(SUB, 0, 32'd5, 32'd3);
        send(SUB, 0, 32'd0, 32'd1);
        send(SUB, 0, 32'h8000_0000, 32'd1);
        send(SET, 3'd0, 32'hFFFF_FFFF, 32'd1);
        send(SET, 3'd1, 32'hFFFF_FFFF, 32'd1);
        send(SET, 3'd3, 32'hFFFF_FFFF, 32'd1);
        send(SET, 3'd5, 32'hFFFF_FFFF, 32'd1);
        send(SET, 3'd4, 32'h1234, 32'h1234);
        send(SET, 3'd5, 32'h1234, 32'h1234);
        send(SET, 3'd6, 32'h1234, 32'h1234);
        send(4'b0011, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        send(MULU, 0, 32'h0001_0000, 32'h0001_0000);
        in_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k < 32)
                chk("mul_busy", {out_valid, in_ready}, 0);
            else
                chk("mul_done", {out_valid, overflow, zero, result},
                    {3'b111, 32'h0});
        end
        send(MULU, 0, 32'h0000_FFFF, 32'h0000_FFFF);
        drain();

        // backpressure: first result must hold until taken
        out_ready = 1'b0;
        t0 = n_take;
        send(ADD, 0, 32'h0000_0100, 32'h0000_0023);
        r0 = 32'h0000_0123;
        fork
            begin
                send(ADD, 0, 32'h1, 32'h1);
                send(ADD, 0, 32'h2, 32'h2);
                send(ADD, 0, 32'h3, 32'h3);
                in_valid = 1'b0;
            end
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold", {out_valid, result}, {1'b1, r0});
                    chk("bp_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bp_takes", n_take - t0, 4);
        drain();

        // reset in the middle of a multiply
        send(MULU, 0, 32'h0000_1234, 32'h0000_5678);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out",
            {out_valid, result, zero, cout, overflow}, 0);
        chk("mid_rst_ready", in_ready, 1);
        void'(exp_q.pop_back());
        rst_n = 1'b1;
        nv = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) nv++;
        end
        chk("aborted_silent", nv, 0);

        ctl8 = MULU; a8 = 8'h10; b8 = 8'h10; v8 = 1'b1;
        @(negedge clk);
        chk("w8_ready", rdy8, 1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("w8_busy", ov8_valid, 0);
        @(posedge clk);
        #1;
        chk("w8_mul", {ov8_valid, ov8, z8, c8, res8},
            {4'b1110, 8'h00});

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send(ops[$urandom_range(0, 9)],
                         3'($urandom_range(0, 7)),
                         pick(), pick());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. Registers every result behind a valid/ready interface, extends the bonus compare set to six signed predicates, and adds a multi-cycle unsigned shift-add multiplier. Sits between operand fetch and writeback; single-cycle ops stream back-to-back, multiplies stall the input side.

## Interface
- WIDTH, 32, operand/result width (>=4)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- src1, src2  in  WIDTH  operands
- alu_ctrl  in  4  operation select
- cmp_ctrl  in  3  compare predicate for SET
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- cout  out  1  carry out (ADD/SUB only)
- overflow  out  1  signed overflow (ADD/SUB), unsigned product overflow (MULU)

## Operation
- alu_ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1101 NAND, 0111 SET, 1000 MULU; any other code -> result 0, flags 0.
- ADD: {cout,result} = src1 + src2. SUB: src1 + ~src2 + 1, cout = carry of that sum (1 = no borrow). overflow = operand signs agree (after inversion for SUB) and result sign differs.
- SET: result = {WIDTH-1 zeros, p}; signed compare, p per cmp_ctrl: 000 lt, 001 gt, 010 le, 011 ge, 100 eq, 101 ne, 110/111 p=0. lt computed without overflow error (sign of src1 when signs differ). cout=overflow=0.
- Logic ops and SET: cout=overflow=0.
- MULU: unsigned shift-add, one multiplier bit per cycle, LSB first; internal 2*WIDTH accumulator. result = low WIDTH bits; overflow = |high WIDTH bits; cout=0.
- zero = ~|result for every op, registered with result.
- FSM: IDLE -> (accept MULU) -> MUL (WIDTH iterations, counter 0..WIDTH-1) -> IDLE with output load. Non-MULU accepts stay in IDLE and load output registers at the accept edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output registers (result, zero, cout, overflow, out_valid) change only on load or on take; held stable while out_valid && !out_ready.
- out_valid clears on take unless a new load occurs on the same edge (load wins, out_valid stays 1).

## Timing
- Reset (rst_n low at edge): state IDLE, out_valid 0, result 0, zero 0, cout 0, overflow 0, counter 0, accumulator 0. in_ready goes to 1 after reset edge.
- Reset during MUL aborts: no output produced, operands discarded.
- Single-cycle ops: accepted at edge N, out_valid=1 after edge N; throughput 1/cycle with out_ready held 1.
- MULU: accepted at edge N, out_valid=1 after edge N+WIDTH; in_ready=0 from after edge N until state returns to IDLE.
- Operands and control sampled only at accept edge; changes afterwards ignored.
- Take and accept on same edge: both occur; new result replaces old.
- in_valid low: no state change except take.

## Test plan
- WIDTH=32 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, out_valid one edge after accept.
- SUB 0x00000005-0x00000003 -> 0x00000002, cout 1; SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, cout 0, overflow 0; SUB 0x80000000-0x00000001 -> overflow 1.
- SET src1=0xFFFFFFFF src2=0x00000001: cmp 000 -> 1, 001 -> 0, 011 -> 0, 101 -> 1; src1=src2=0x1234: cmp 100 -> 1 zero 0, cmp 101 -> 0 zero 1; cmp 110 -> 0.
- MULU 0x00010000*0x00010000 -> result 0, overflow 1, zero 1, out_valid exactly 32 edges after accept, in_ready 0 throughout; MULU 0x0000FFFF*0x0000FFFF -> 0xFFFE0001, overflow 0.
- Backpressure: stream 4 ADDs with out_ready=0 after first -> first result held stable, in_ready 0; raise out_ready -> remaining three results in order, one per cycle, none lost or duplicated.
- Reset mid-MULU at iteration 10 -> all outputs 0, out_valid never asserts for aborted op; WIDTH=8 instance: MULU 0x10*0x10 -> 0x00, overflow 1 after 8 edges.
